// File: rtl/wimax_pkg.sv
// ---------------------------------------------------------------------------
// wimax_pkg
// Shared constants and types for the WiMAX PHY interleaving blocks.
//   NCBPS_QPSK  : coded bits per block for QPSK rate 1/2
//   INTLV_D     : interleaver column count
//   INTLV_ROWS  : NCBPS_QPSK / INTLV_D
//   intlv_addr_t: bit address inside one block
//   bank_sel_t  : ping-pong bank selector
// ---------------------------------------------------------------------------
package wimax_pkg;
  localparam int NCBPS_QPSK = 192;
  localparam int INTLV_D    = 16;
  localparam int INTLV_ROWS = 12;

  typedef logic [7:0] intlv_addr_t;
  typedef logic       bank_sel_t;
endpackage

// File: rtl/wimax_deintlv_addr_gen.sv
// ---------------------------------------------------------------------------
// wimax_deintlv_addr_gen
// Produces the deinterleaver write address waddr = D*(j mod ROWS) + j/ROWS
// for the j-th accepted bit of a block, using only adds (no multiplier).
// Ports:
//   clk       : clock
//   reset     : synchronous, active-high
//   advance_i : one bit accepted this cycle; step to the next address
//   waddr_o   : write address for the bit accepted this cycle
//   wrap_o    : high when the last bit of a block is accepted this cycle
// ---------------------------------------------------------------------------
module wimax_deintlv_addr_gen
  import wimax_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance_i,
  output intlv_addr_t waddr_o,
  output logic        wrap_o
);

  localparam int ROWS = NCBPS / D;

  logic [3:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  intlv_addr_t waddr_q, waddr_d;
  logic        last_col, last_row;

  assign last_col = (col_q == 4'(ROWS - 1));
  assign last_row = (row_q == 4'(D - 1));
  assign wrap_o   = advance_i && last_col && last_row;
  assign waddr_o  = waddr_q;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    waddr_d = waddr_q;
    if (advance_i) begin
      if (last_col) begin
        // Column of the block matrix exhausted: restart at the next row
        // offset, or at zero once the whole block has been written.
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          waddr_d = '0;
        end else begin
          row_d   = row_q + 4'd1;
          waddr_d = intlv_addr_t'(row_q) + intlv_addr_t'(1);
        end
      end else begin
        col_d   = col_q + 4'd1;
        waddr_d = waddr_q + intlv_addr_t'(D);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      waddr_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: rtl/wimax_deinterleaver.sv
// ---------------------------------------------------------------------------
// wimax_deinterleaver
// Receive-side block deinterleaver (QPSK 1/2, Ncbps=192, d=16, s=1).
// Interleaved bits are written in permuted order into one bank of a two-bank
// ping-pong store; a full bank is read out sequentially in original order.
// Ports:
//   clk         : clock
//   reset       : synchronous, active-high
//   data_in     : received bit (interleaved order)
//   valid_in    : data_in valid
//   ready_out   : a bit can be accepted
//   data_out    : deinterleaved bit
//   valid_out   : data_out valid
//   ready_in    : downstream accepts data_out
//   block_start : first bit of each output block (only with
//                 WIMAX_DEINTLV_MARK_EN defined)
// ---------------------------------------------------------------------------
module wimax_deinterleaver
  import wimax_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in
`ifdef WIMAX_DEINTLV_MARK_EN
  ,
  output logic block_start
`endif
);

  logic [NCBPS-1:0] bank0_q, bank1_q;
  logic [1:0]       full_q, full_d;
  bank_sel_t        wbank_q, wbank_d;
  bank_sel_t        rbank_q, rbank_d;
  intlv_addr_t      raddr_q, raddr_d;
  intlv_addr_t      waddr;
  logic             wrap;
  logic             in_fire, out_fire, last_rd, rd_bit;

  wimax_deintlv_addr_gen #(
    .NCBPS (NCBPS),
    .D     (D)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .advance_i (in_fire),
    .waddr_o   (waddr),
    .wrap_o    (wrap)
  );

  // Handshake outputs are forced low while reset is asserted.
  assign ready_out = !reset && !full_q[wbank_q];
  assign valid_out = !reset && full_q[rbank_q];
  assign in_fire   = valid_in && ready_out;
  assign out_fire  = valid_out && ready_in;
  assign last_rd   = (raddr_q == intlv_addr_t'(NCBPS - 1));

  assign rd_bit   = rbank_q ? bank1_q[raddr_q] : bank0_q[raddr_q];
  // Unreset storage is masked so data_out reads 0 when nothing is valid.
  assign data_out = valid_out && rd_bit;

`ifdef WIMAX_DEINTLV_MARK_EN
  assign block_start = valid_out && (raddr_q == '0);
`endif

  // A bank being written is never full and a bank being read always is, so
  // the fill and drain updates below touch different full flags and may
  // both land in the same cycle.
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    raddr_d = raddr_q;
    if (wrap) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (out_fire) begin
      if (last_rd) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        raddr_d         = '0;
      end else begin
        raddr_d = raddr_q + intlv_addr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      raddr_q <= raddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (wbank_q) bank1_q[waddr] <= data_in;
      else         bank0_q[waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_wimax_deinterleaver.sv
module tb_wimax_deinterleaver;
  localparam int N    = 192;
  localparam int DD   = 16;
  localparam int RR   = N / DD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic valid_in = 1'b0;
  logic ready_in = 1'b0;
  logic ready_out, data_out, valid_out;
`ifdef WIMAX_DEINTLV_MARK_EN
  logic block_start;
`endif

  wimax_deinterleaver dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef WIMAX_DEINTLV_MARK_EN
    ,
    .block_start (block_start)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // reference model state
  bit       pbuf [N];
  int       pcnt = 0;
  bit       exp_q [$];
  bit [N-1:0] outv;
  int       out_idx = 0;

  // per-step observations
  bit obs_ready, obs_valid, acc, ofire, obit;
  bit hold_pending = 0;
  bit hold_bit = 0;

  task automatic check(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input bit [N-1:0] obs, input bit [N-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Block permutation from the interleaver definition: received index j
  // holds original bit k = D*(j mod ROWS) + floor(j/ROWS).
  task automatic model_accept(input bit b);
    bit ob [N];
    pbuf[pcnt] = b;
    pcnt++;
    if (pcnt == N) begin
      for (int j = 0; j < N; j++) ob[DD * (j % RR) + j / RR] = pbuf[j];
      for (int k = 0; k < N; k++) exp_q.push_back(ob[k]);
      pcnt = 0;
    end
  endtask

  task automatic step(input bit vin, input bit din, input bit rin);
    bit e;
    @(negedge clk);
    valid_in = vin;
    data_in  = din;
    ready_in = rin;
    obs_ready = ready_out;
    obs_valid = valid_out;
    if (hold_pending && valid_out) check("hold_stable", data_out, hold_bit);
    hold_pending = valid_out && !rin;
    hold_bit = data_out;
`ifdef WIMAX_DEINTLV_MARK_EN
    check("block_start", block_start, (valid_out && out_idx == 0));
`endif
    acc   = vin && ready_out;
    ofire = valid_out && rin;
    obit  = data_out;
    if (acc) model_accept(din);
    if (ofire) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("data", obit, e);
      end
      outv[out_idx] = obit;
      out_idx = (out_idx + 1) % N;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", ready_out, 0);
    check("rst_valid_low", valid_out, 0);
    pcnt = 0;
    exp_q.delete();
    hold_pending = 0;
    out_idx = 0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", ready_out, 1);
    check("post_rst_valid", valid_out, 0);
    @(posedge clk);
  endtask

  task automatic feed_block(input bit [N-1:0] blk, input bit rin);
    for (int j = 0; j < N; j++) begin
      int guard = 0;
      do begin
        step(1'b1, blk[j], rin);
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("feed_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic impulse(input int j, input int k);
    bit [N-1:0] blk;
    bit [N-1:0] want;
    blk = '0;
    blk[j] = 1'b1;
    want = '0;
    want[k] = 1'b1;
    feed_block(blk, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("latency_valid", obs_valid, 1);
    drain();
    check_vec("impulse", outv, want);
  endtask

  initial begin
    bit [N-1:0] blk;
    int n, first, gaps, lows, outs;
    do_reset();

    // impulses
    impulse(12, 1);
    impulse(1, 16);
    impulse(191, 191);
    impulse(0, 0);

    // full permutation with a deterministic pattern
    for (int j = 0; j < N; j++) blk[j] = $countones(j) % 2 == 1 ? ~((j * 7 >> 2) & 1) : ((j * 7 >> 2) & 1);
    feed_block(blk, 1'b0);
    drain();

    // streaming: 3 back-to-back random blocks, ready_in high
    n = 0; first = -1; gaps = 0; lows = 0; outs = 0;
    for (int c = 0; c < 1200 && outs < 3 * N; c++) begin
      if (n < 3 * N) begin
        step(1'b1, 1'($urandom), 1'b1);
        if (!obs_ready) lows++;
        if (acc) n++;
      end else begin
        step(1'b0, 1'b0, 1'b1);
      end
      if (ofire) begin
        if (first < 0) first = c;
        outs++;
      end else if (first >= 0) begin
        gaps++;
      end
    end
    check("stream_first_valid", first, N);
    check("stream_ready_lows", lows, 0);
    check("stream_outs", outs, 3 * N);
    check("stream_gaps", gaps, 0);
    check("stream_empty", exp_q.size(), 0);

    // backpressure: 400 presented bits, downstream stalled
    n = 0;
    for (int c = 0; c < 400; c++) begin
      step(1'b1, 1'($urandom), 1'b0);
      if (acc) n++;
    end
    check("bp_accepts", n, 2 * N);
    check("bp_ready_low", obs_ready, 0);
    n = 0;
    for (int c = 0; c < 500; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (obs_ready) break;
      if (ofire) n++;
    end
    check("bp_ready_rise", obs_ready, 1);
    check("bp_xfers_before_ready", n, N);
    drain();

    // reset with one full bank and 100 bits of a partial block
    for (int j = 0; j < N; j++) blk[j] = 1'($urandom);
    feed_block(blk, 1'b0);
    for (int j = 0; j < 100; j++) step(1'b1, 1'($urandom), 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    check("after_rst_no_valid", obs_valid, 0);
    for (int j = 0; j < N; j++) blk[j] = 1'($urandom);
    feed_block(blk, 1'b0);
    drain();

    // random handshake traffic against the scoreboard
    for (int c = 0; c < 3000; c++)
      step(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 3) != 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
